// File: rtl/avalon_arb_pkg.sv
// Shared types and widths for the two-master Avalon-MM arbiter.
// Imported by the interface, the select mux and the arbiter top.
package avalon_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  // One-hot grant seen by the mux and exported for debug.
  function automatic logic [1:0] grant_of(state_e st);
    logic [1:0] g;
    g = 2'b00;
    unique case (st)
      GNT0:    g = 2'b01;
      GNT1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/avalon_arbiter_if.sv
// Avalon-MM signal bundle. "master" drives the request side,
// "slave" drives waitrequest/readdata back.
interface avalon_arbiter_if;
  import avalon_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/avalon_arb_mux.sv
// Purely combinational routing between the two masters and the RAM,
// steered by the one-hot grant. No grant parks the RAM bus at zero.
module avalon_arb_mux
  import avalon_arb_pkg::*;
(
  input  logic [1:0]        grant_i,

  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic              m0_read_i,
  input  logic              m0_write_i,
  input  logic [DATA_W-1:0] m0_writedata_i,
  input  logic [BE_W-1:0]   m0_byteenable_i,
  output logic              m0_waitrequest_o,
  output logic [DATA_W-1:0] m0_readdata_o,

  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic              m1_read_i,
  input  logic              m1_write_i,
  input  logic [DATA_W-1:0] m1_writedata_i,
  input  logic [BE_W-1:0]   m1_byteenable_i,
  output logic              m1_waitrequest_o,
  output logic [DATA_W-1:0] m1_readdata_o,

  output logic [ADDR_W-1:0] ram_address_o,
  output logic              ram_read_o,
  output logic              ram_write_o,
  output logic [DATA_W-1:0] ram_writedata_o,
  output logic [BE_W-1:0]   ram_byteenable_o,
  input  logic              ram_waitrequest_i,
  input  logic [DATA_W-1:0] ram_readdata_i
);

  always_comb begin
    ram_address_o    = '0;
    ram_read_o       = 1'b0;
    ram_write_o      = 1'b0;
    ram_writedata_o  = '0;
    ram_byteenable_o = '0;
    m0_waitrequest_o = 1'b1;
    m1_waitrequest_o = 1'b1;
    m0_readdata_o    = '0;
    m1_readdata_o    = '0;

    unique case (grant_i)
      2'b01: begin
        ram_address_o    = m0_address_i;
        ram_read_o       = m0_read_i;
        ram_write_o      = m0_write_i;
        ram_writedata_o  = m0_writedata_i;
        ram_byteenable_o = m0_byteenable_i;
        m0_waitrequest_o = ram_waitrequest_i;
        m0_readdata_o    = ram_readdata_i;
      end
      2'b10: begin
        ram_address_o    = m1_address_i;
        ram_read_o       = m1_read_i;
        ram_write_o      = m1_write_i;
        ram_writedata_o  = m1_writedata_i;
        ram_byteenable_o = m1_byteenable_i;
        m1_waitrequest_o = ram_waitrequest_i;
        m1_readdata_o    = ram_readdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/avalon_arbiter.sv
// Two-master to one-RAM Avalon-MM arbiter: IDLE/GNT0/GNT1 FSM with
// round-robin or fixed-priority tie break and one bubble between grants.
module avalon_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                reset,
  avalon_arbiter_if.slave     m0,
  avalon_arbiter_if.slave     m1,
  avalon_arbiter_if.master    ram,
  output logic [1:0]          grant
);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   req0, req1;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          // last_grant_q == 1 means m1 was served last, so m0 is next.
          state_d = ((FIXED_PRIORITY != 0) || last_grant_q) ? GNT0 : GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!req0) begin
          state_d = IDLE;
        end else if (!ram.waitrequest) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d = IDLE;
        end else if (!ram.waitrequest) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = grant_of(state_q);
  end

  avalon_arb_mux u_mux (
    .grant_i           (grant),
    .m0_address_i      (m0.address),
    .m0_read_i         (m0.read),
    .m0_write_i        (m0.write),
    .m0_writedata_i    (m0.writedata),
    .m0_byteenable_i   (m0.byteenable),
    .m0_waitrequest_o  (m0.waitrequest),
    .m0_readdata_o     (m0.readdata),
    .m1_address_i      (m1.address),
    .m1_read_i         (m1.read),
    .m1_write_i        (m1.write),
    .m1_writedata_i    (m1.writedata),
    .m1_byteenable_i   (m1.byteenable),
    .m1_waitrequest_o  (m1.waitrequest),
    .m1_readdata_o     (m1.readdata),
    .ram_address_o     (ram.address),
    .ram_read_o        (ram.read),
    .ram_write_o       (ram.write),
    .ram_writedata_o   (ram.writedata),
    .ram_byteenable_o  (ram.byteenable),
    .ram_waitrequest_i (ram.waitrequest),
    .ram_readdata_i    (ram.readdata)
  );

endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed bench for avalon_arbiter: per-cycle grant/bus checks plus a
// completion scoreboard; a fixed-priority copy shares the master requests.
module tb_avalon_arbiter;
  import avalon_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant_rr, grant_fp;

  always #5 clk = ~clk;

  avalon_arbiter_if m0_if ();
  avalon_arbiter_if m1_if ();
  avalon_arbiter_if ram_if ();
  avalon_arbiter_if m0_fp ();
  avalon_arbiter_if m1_fp ();
  avalon_arbiter_if ram_fp ();

  avalon_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .ram   (ram_if),
    .grant (grant_rr)
  );

  avalon_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_fp),
    .m1    (m1_fp),
    .ram   (ram_fp),
    .grant (grant_fp)
  );

  assign m0_fp.address     = m0_if.address;
  assign m0_fp.read        = m0_if.read;
  assign m0_fp.write       = m0_if.write;
  assign m0_fp.writedata   = m0_if.writedata;
  assign m0_fp.byteenable  = m0_if.byteenable;
  assign m1_fp.address     = m1_if.address;
  assign m1_fp.read        = m1_if.read;
  assign m1_fp.write       = m1_if.write;
  assign m1_fp.writedata   = m1_if.writedata;
  assign m1_fp.byteenable  = m1_if.byteenable;
  assign ram_fp.waitrequest = 1'b0;
  assign ram_fp.readdata    = 32'h0;

  typedef struct packed {
    logic        master;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Completion monitor: a granted, requesting master with waitrequest low.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !ram_if.waitrequest) begin
      if (grant_rr == 2'b01 && (m0_if.read || m0_if.write)) begin
        if (sb.size() == 0) check_eq("sb_underflow_m0", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          check_eq("sb_master_m0", 32'd0, {31'd0, e.master});
          check_eq("sb_data_m0", m0_if.read ? m0_if.readdata : ram_if.writedata, e.data);
        end
      end else if (grant_rr == 2'b10 && (m1_if.read || m1_if.write)) begin
        if (sb.size() == 0) check_eq("sb_underflow_m1", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          check_eq("sb_master_m1", 32'd1, {31'd0, e.master});
          check_eq("sb_data_m1", m1_if.read ? m1_if.readdata : ram_if.writedata, e.data);
        end
      end
    end
  end

  task automatic clear_masters();
    m0_if.address = '0; m0_if.read = 1'b0; m0_if.write = 1'b0;
    m0_if.writedata = '0; m0_if.byteenable = '0;
    m1_if.address = '0; m1_if.read = 1'b0; m1_if.write = 1'b0;
    m1_if.writedata = '0; m1_if.byteenable = '0;
  endtask

  logic [1:0] rr_seq [6];
  logic [1:0] fp_seq [6];

  initial begin
    rr_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    fp_seq = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    reset = 1'b1;
    clear_masters();
    ram_if.waitrequest = 1'b1;
    ram_if.readdata    = '0;
    cyc();
    cyc();
    reset = 1'b0;
    smp();
    check_eq("rst_grant", 32'(grant_rr), 32'd0);
    check_eq("rst_ram_read", 32'(ram_if.read), 32'd0);
    check_eq("rst_ram_addr", ram_if.address, 32'd0);
    check_eq("rst_m0_wait", 32'(m0_if.waitrequest), 32'd1);
    check_eq("rst_m1_wait", 32'(m1_if.waitrequest), 32'd1);

    // Single read from m0, RAM ready on the second granted cycle.
    cyc();
    m0_if.read = 1'b1; m0_if.address = 32'h100;
    smp();
    check_eq("rd_idle_grant", 32'(grant_rr), 32'd0);
    check_eq("rd_idle_m0_wait", 32'(m0_if.waitrequest), 32'd1);
    cyc();
    smp();
    check_eq("rd_g0_grant", 32'(grant_rr), 32'd1);
    check_eq("rd_g0_ram_read", 32'(ram_if.read), 32'd1);
    check_eq("rd_g0_ram_addr", ram_if.address, 32'h100);
    check_eq("rd_g0_m0_wait", 32'(m0_if.waitrequest), 32'd1);
    check_eq("rd_g0_m1_wait", 32'(m1_if.waitrequest), 32'd1);
    cyc();
    ram_if.waitrequest = 1'b0; ram_if.readdata = 32'hDEADBEEF;
    sb.push_back('{master: 1'b0, data: 32'hDEADBEEF});
    smp();
    check_eq("rd_done_m0_wait", 32'(m0_if.waitrequest), 32'd0);
    check_eq("rd_done_m0_data", m0_if.readdata, 32'hDEADBEEF);
    check_eq("rd_done_m1_wait", 32'(m1_if.waitrequest), 32'd1);
    check_eq("rd_done_m1_data", m1_if.readdata, 32'd0);
    cyc();
    m0_if.read = 1'b0; ram_if.waitrequest = 1'b1;
    smp();
    check_eq("rd_after_grant", 32'(grant_rr), 32'd0);

    // Continuous tie from reset: round-robin alternates, fixed priority keeps m0.
    cyc();
    reset = 1'b1;
    m0_if.read = 1'b1; m0_if.address = 32'h40;
    m1_if.read = 1'b1; m1_if.address = 32'h80;
    ram_if.waitrequest = 1'b0; ram_if.readdata = 32'h5555AAAA;
    cyc();
    reset = 1'b0;
    sb.push_back('{master: 1'b0, data: 32'h5555AAAA});
    sb.push_back('{master: 1'b1, data: 32'h5555AAAA});
    sb.push_back('{master: 1'b0, data: 32'h5555AAAA});
    for (int i = 0; i < 6; i++) begin
      smp();
      check_eq($sformatf("tie_rr_%0d", i), 32'(grant_rr), 32'(rr_seq[i]));
      check_eq($sformatf("tie_fp_%0d", i), 32'(grant_fp), 32'(fp_seq[i]));
      cyc();
    end
    clear_masters();
    ram_if.waitrequest = 1'b1;

    // Stalled write from m1: five wait cycles then accepted.
    m1_if.write = 1'b1; m1_if.address = 32'h200;
    m1_if.writedata = 32'h12345678; m1_if.byteenable = 4'b0011;
    smp();
    check_eq("wr_idle_grant", 32'(grant_rr), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 5) begin
        ram_if.waitrequest = 1'b0;
        sb.push_back('{master: 1'b1, data: 32'h12345678});
      end
      smp();
      check_eq($sformatf("wr_grant_%0d", i), 32'(grant_rr), 32'd2);
      check_eq($sformatf("wr_m1_wait_%0d", i), 32'(m1_if.waitrequest), (i < 5) ? 32'd1 : 32'd0);
      if (i == 0 || i == 5) begin
        check_eq($sformatf("wr_ram_write_%0d", i), 32'(ram_if.write), 32'd1);
        check_eq($sformatf("wr_ram_data_%0d", i), ram_if.writedata, 32'h12345678);
        check_eq($sformatf("wr_ram_be_%0d", i), 32'(ram_if.byteenable), 32'h3);
        check_eq($sformatf("wr_m0_wait_%0d", i), 32'(m0_if.waitrequest), 32'd1);
      end
    end
    cyc();
    clear_masters();
    ram_if.waitrequest = 1'b1;
    smp();
    check_eq("wr_after_grant", 32'(grant_rr), 32'd0);

    // m0 completes so last_grant=0, then reset during a stalled m0 read.
    cyc();
    m0_if.read = 1'b1; m0_if.address = 32'h300;
    ram_if.waitrequest = 1'b0; ram_if.readdata = 32'hCAFE0001;
    sb.push_back('{master: 1'b0, data: 32'hCAFE0001});
    cyc();
    cyc();
    m0_if.read = 1'b0; ram_if.waitrequest = 1'b1;
    cyc();
    m0_if.read = 1'b1;
    cyc();
    smp();
    check_eq("rst_mid_g0", 32'(grant_rr), 32'd1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m1_if.read = 1'b1; m1_if.address = 32'h400;
    smp();
    check_eq("rst_mid_grant", 32'(grant_rr), 32'd0);
    check_eq("rst_mid_ram_read", 32'(ram_if.read), 32'd0);
    check_eq("rst_mid_m0_wait", 32'(m0_if.waitrequest), 32'd1);
    cyc();
    smp();
    check_eq("rst_mid_tie_m0", 32'(grant_rr), 32'd1);
    cyc();
    ram_if.waitrequest = 1'b0; ram_if.readdata = 32'hCAFE0002;
    sb.push_back('{master: 1'b0, data: 32'hCAFE0002});
    cyc();
    clear_masters();
    ram_if.waitrequest = 1'b1;

    // Abort by m1 must not move last_grant (still 0, so m1 wins next tie).
    cyc();
    m1_if.read = 1'b1; m1_if.address = 32'h500;
    cyc();
    smp();
    check_eq("abort_g1", 32'(grant_rr), 32'd2);
    cyc();
    m1_if.read = 1'b0;
    cyc();
    smp();
    check_eq("abort_idle", 32'(grant_rr), 32'd0);
    m0_if.read = 1'b1; m1_if.read = 1'b1;
    cyc();
    smp();
    check_eq("abort_tie_m1", 32'(grant_rr), 32'd2);
    cyc();
    ram_if.waitrequest = 1'b0; ram_if.readdata = 32'hBEEF0003;
    sb.push_back('{master: 1'b1, data: 32'hBEEF0003});
    cyc();
    clear_masters();
    ram_if.waitrequest = 1'b1;
    cyc();
    cyc();

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
